lcd_pattern_gen: RTL and testbench
==================================

Name: lcd_pattern_gen

Overview:
- Parametrised test-pattern source for the LCD pixel writer. Generalises the fixed single-colour bench source into a resolution-aware generator with four modes: solid, 8-colour bars, checkerboard and horizontal grey ramp.
- Answers the writer's per-pixel data_req with registered rgb plus data_valid.
- Tracks the raster position internally.
- Latches mode and colour changes only at frame boundaries, so a frame is never torn.

Parameters:
- H_ACTIVE, 480, active pixels per line (>=8)
- V_ACTIVE, 272, active lines per frame (>=1)
- CHECK_LOG2, 4, checker cell edge = 2**CHECK_LOG2 pixels
- GRAD_SHIFT, 1, ramp grey level = x >> GRAD_SHIFT, saturated at 255
- FRAME_CNT_W, 16, width of frame counter

Ports:
- clk  in  1  pixel-domain clock
- rst  in  1  asynchronous active-low reset
- mode  in  2  0 solid, 1 bars, 2 checker, 3 ramp
- color_fg  in  24  RGB888; solid colour / checker "on" cell
- color_bg  in  24  RGB888; checker "off" cell / blank colour
- enable  in  1  0 forces blank (color_bg) output; counters still advance
- frame_sync  in  1  synchronous restart of raster at (0,0)
- data_req  in  1  pixel request from writer, one pixel per high cycle
- rgb  out  24  registered pixel, RGB888 (red 23:16, green 15:8, blue 7:0)
- data_valid  out  1  rgb valid this cycle
- frame_start  out  1  one-cycle pulse alongside data_valid for pixel (0,0)
- frame_cnt  out  FRAME_CNT_W  completed-frame count, wraps

Behaviour:
- Reset (rst=0, async): rgb=0, data_valid=0, frame_start=0, frame_cnt=0, x=y=0, bar index=0, shadow mode=0, shadow colours=0.
- Handshake: data_req high in cycle N means the pixel at current (x,y) is presented in cycle N+1 with data_valid=1. Latency is exactly 1. Back-to-back requests sustain 1 pixel/cycle.
- data_req low in cycle N: data_valid=0 in N+1, rgb holds its last value, position is unchanged.
- Raster advance per accepted request:
  - x++.
  - At x=H_ACTIVE-1: x=0, y++.
  - At (H_ACTIVE-1, V_ACTIVE-1): y=0 and frame_cnt++ (wraps at 2**FRAME_CNT_W).
- Shadow latch: mode, color_fg and color_bg are copied into shadow registers when a request is accepted at (0,0). All pixels of that frame use the shadow values. Live inputs are ignored mid-frame. enable is live, not shadowed.
- Pixel function (shadow values):
  - solid: color_fg.
  - bars: bar index starts at 0 each line and increments every BAR_W=H_ACTIVE/8 pixels, saturating at 7; the last bar absorbs the remainder. Colours by index 0..7: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000. No divider: index comes from a per-line sub-counter.
  - checker: color_fg if (x[CHECK_LOG2] XOR y[CHECK_LOG2]) = 0, else color_bg.
  - ramp: g = min(x>>GRAD_SHIFT, 255); rgb = {g,g,g}.
  - enable=0: color_bg regardless of mode.
- frame_sync (single-cycle effect):
  - Resets x, y and bar index to 0. frame_cnt is not incremented.
  - If data_req is also high that cycle, the accepted pixel is (0,0): shadows latch, frame_start pulses, and the next position is (1,0).
  - frame_sync at (0,0) is harmless.
- frame_start: high exactly in the data_valid cycle carrying pixel (0,0), whether reached by natural wrap, by frame_sync, or as the first pixel after reset.
- Mid-frame reset: all state returns to reset values. The next request produces (0,0) with frame_start=1.

Optional Feature:
- Macro LCD_PATTERN_SCROLL_EN.
- Defined: the pattern scrolls horizontally by one pixel per frame. The pixel function uses xs = (x + frame_cnt) mod H_ACTIVE in place of x, via a modular offset register reset to 0 and incremented with wrap at each frame wrap. This applies to bars, checker and ramp; solid is unaffected. The bar index derives from xs through a second sub-counter preloaded from the offset at each line start.
- Undefined: no offset logic, xs=x, and output is identical frame to frame.

Test Plan:
- Reset, then mode=0, color_fg=0000FF, data_req held high: data_valid=1 from the 2nd cycle, every rgb=0000FF, frame_start first at pixel 0, then every 480*272 requests; frame_cnt=1 after 130560 requests.
- H_ACTIVE=16, V_ACTIVE=2, mode=1, continuous req: per line rgb = pairs FFFFFF,FFFFFF,FFFF00,FFFF00,... ending 000000,000000; H_ACTIVE=20 gives last bar 000000 for 6 pixels.
- CHECK_LOG2=1, H=8, V=4, fg=FFFFFF, bg=000000, mode=2: line 0 = W,W,B,B,W,W,B,B; line 2 inverted.
- Change mode 0->3 mid-frame: remainder of frame unchanged; next frame line 0 with GRAD_SHIFT=0, H=300: grey 0..255 then 255 for x=256..299.
- Gapped data_req (1 of 3 cycles), frame_sync with data_req at position (5,1): the accepted pixel is (0,0) with frame_start=1, the next pixel is (1,0), frame_cnt unchanged, data_valid low on non-request cycles.
- Pull rst low mid-line: outputs 0 asynchronously; after release, the first request gives frame_start=1. With LCD_PATTERN_SCROLL_EN and mode=1, H=16: frame 1 pixel 0 = FFFFFF, pixel 1 = FFFF00.

Source files
------------

// File: rtl/lcd_pattern_gen.sv
// lcd_pattern_gen: resolution-aware test-pattern source (solid, bars, checker, grey ramp) for the LCD pixel writer.
// Optional horizontal scroll per frame is enabled by defining LCD_PATTERN_SCROLL_EN.
`default_nettype none

module lcd_pattern_gen #(
    parameter int H_ACTIVE    = 480,
    parameter int V_ACTIVE    = 272,
    parameter int CHECK_LOG2  = 4,
    parameter int GRAD_SHIFT  = 1,
    parameter int FRAME_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             mode,
    input  logic [23:0]            color_fg,
    input  logic [23:0]            color_bg,
    input  logic                   enable,
    input  logic                   frame_sync,
    input  logic                   data_req,
    output logic [23:0]            rgb,
    output logic                   data_valid,
    output logic                   frame_start,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam int BAR_W = H_ACTIVE / 8;
    localparam int XW    = $clog2(H_ACTIVE);
    localparam int YW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int RW    = XW - GRAD_SHIFT;

    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BAR_W - 1);

    localparam logic [1:0] M_SOLID = 2'd0;
    localparam logic [1:0] M_BARS  = 2'd1;
    localparam logic [1:0] M_CHECK = 2'd2;
    localparam logic [1:0] M_RAMP  = 2'd3;

    logic [XW-1:0]          x_q, x_d;
    logic [YW-1:0]          y_q, y_d;
    logic [2:0]             bidx_q, bidx_d;
    logic [BW-1:0]          bcnt_q, bcnt_d;
    logic [1:0]             mode_q, mode_d;
    logic [23:0]            fg_q, fg_d;
    logic [23:0]            bg_q, bg_d;
    logic [23:0]            rgb_q, rgb_d;
    logic                   valid_q, valid_d;
    logic                   fstart_q, fstart_d;
    logic [FRAME_CNT_W-1:0] fcnt_q, fcnt_d;

    // Position/bar state as seen by this cycle's request (frame_sync forces the origin)
    logic [XW-1:0] w_x, w_xs;
    logic [YW-1:0] w_y;
    logic [2:0]    w_bidx;
    logic [BW-1:0] w_bcnt;
    logic          w_origin;
    logic [1:0]    w_mode;
    logic [23:0]   w_fg, w_bg, w_pix;
    logic          w_cx, w_cy;
    logic [7:0]    w_grey;

`ifdef LCD_PATTERN_SCROLL_EN
    logic [XW-1:0] off_q, off_d, xs_q, xs_d;
    logic [2:0]    oidx_q, oidx_d;
    logic [BW-1:0] ocnt_q, ocnt_d;
`endif

    function automatic logic [BW+2:0] bar_step(input logic [2:0] idx, input logic [BW-1:0] cnt);
        if (idx == 3'd7)
            return {idx, cnt};
        else if (cnt == B_LAST)
            return {idx + 3'd1, {BW{1'b0}}};
        else
            return {idx, cnt + 1'b1};
    endfunction

    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return 24'hFFFFFF;
            3'd1:    return 24'hFFFF00;
            3'd2:    return 24'h00FFFF;
            3'd3:    return 24'h00FF00;
            3'd4:    return 24'hFF00FF;
            3'd5:    return 24'hFF0000;
            3'd6:    return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    assign w_x = frame_sync ? '0 : x_q;
    assign w_y = frame_sync ? '0 : y_q;
`ifdef LCD_PATTERN_SCROLL_EN
    assign w_xs   = frame_sync ? off_q  : xs_q;
    assign w_bidx = frame_sync ? oidx_q : bidx_q;
    assign w_bcnt = frame_sync ? ocnt_q : bcnt_q;
`else
    assign w_xs   = w_x;
    assign w_bidx = frame_sync ? 3'd0 : bidx_q;
    assign w_bcnt = frame_sync ? '0   : bcnt_q;
`endif
    assign w_origin = (w_x == '0) && (w_y == '0);

    // Pixel (0,0) uses the live inputs it is latching into the shadows
    assign w_mode = w_origin ? mode     : mode_q;
    assign w_fg   = w_origin ? color_fg : fg_q;
    assign w_bg   = w_origin ? color_bg : bg_q;

    generate
        if (CHECK_LOG2 < XW) begin : g_cx_bit
            assign w_cx = w_xs[CHECK_LOG2];
        end else begin : g_cx_zero
            assign w_cx = 1'b0;
        end
        if (CHECK_LOG2 < YW) begin : g_cy_bit
            assign w_cy = w_y[CHECK_LOG2];
        end else begin : g_cy_zero
            assign w_cy = 1'b0;
        end
        if (RW > 8) begin : g_ramp_sat
            logic [XW-1:0] w_sh;
            assign w_sh   = w_xs >> GRAD_SHIFT;
            assign w_grey = (|w_sh[XW-1:8]) ? 8'hFF : w_sh[7:0];
        end else begin : g_ramp_narrow
            assign w_grey = 8'(w_xs >> GRAD_SHIFT);
        end
    endgenerate

    always_comb begin
        w_pix = w_bg;
        if (enable) begin
            case (w_mode)
                M_SOLID: w_pix = w_fg;
                M_BARS:  w_pix = bar_color(w_bidx);
                M_CHECK: w_pix = (w_cx ^ w_cy) ? w_bg : w_fg;
                M_RAMP:  w_pix = {w_grey, w_grey, w_grey};
                default: w_pix = w_bg;
            endcase
        end
    end

    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        bidx_d   = bidx_q;
        bcnt_d   = bcnt_q;
        mode_d   = mode_q;
        fg_d     = fg_q;
        bg_d     = bg_q;
        rgb_d    = rgb_q;
        fcnt_d   = fcnt_q;
        valid_d  = data_req;
        fstart_d = data_req && w_origin;
`ifdef LCD_PATTERN_SCROLL_EN
        off_d    = off_q;
        xs_d     = xs_q;
        oidx_d   = oidx_q;
        ocnt_d   = ocnt_q;
`endif
        if (frame_sync) begin
            x_d    = '0;
            y_d    = '0;
            bidx_d = w_bidx;
            bcnt_d = w_bcnt;
`ifdef LCD_PATTERN_SCROLL_EN
            xs_d   = off_q;
`endif
        end
        if (data_req) begin
            rgb_d = w_pix;
            if (w_origin) begin
                mode_d = mode;
                fg_d   = color_fg;
                bg_d   = color_bg;
            end
            if (w_x == X_LAST) begin
                x_d = '0;
                if (w_y == Y_LAST) begin
                    y_d    = '0;
                    fcnt_d = fcnt_q + 1'b1;
`ifdef LCD_PATTERN_SCROLL_EN
                    if (off_q == X_LAST) begin
                        off_d  = '0;
                        oidx_d = 3'd0;
                        ocnt_d = '0;
                    end else begin
                        off_d            = off_q + 1'b1;
                        {oidx_d, ocnt_d} = bar_step(oidx_q, ocnt_q);
                    end
`endif
                end else begin
                    y_d = w_y + 1'b1;
                end
`ifdef LCD_PATTERN_SCROLL_EN
                // Each line restarts at the (possibly just advanced) frame offset
                xs_d   = off_d;
                bidx_d = oidx_d;
                bcnt_d = ocnt_d;
`else
                bidx_d = 3'd0;
                bcnt_d = '0;
`endif
            end else begin
                x_d = w_x + 1'b1;
`ifdef LCD_PATTERN_SCROLL_EN
                if (w_xs == X_LAST) begin
                    xs_d   = '0;
                    bidx_d = 3'd0;
                    bcnt_d = '0;
                end else begin
                    xs_d             = w_xs + 1'b1;
                    {bidx_d, bcnt_d} = bar_step(w_bidx, w_bcnt);
                end
`else
                {bidx_d, bcnt_d} = bar_step(w_bidx, w_bcnt);
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q      <= '0;
            y_q      <= '0;
            bidx_q   <= 3'd0;
            bcnt_q   <= '0;
            mode_q   <= 2'd0;
            fg_q     <= 24'd0;
            bg_q     <= 24'd0;
            rgb_q    <= 24'd0;
            valid_q  <= 1'b0;
            fstart_q <= 1'b0;
            fcnt_q   <= '0;
`ifdef LCD_PATTERN_SCROLL_EN
            off_q    <= '0;
            xs_q     <= '0;
            oidx_q   <= 3'd0;
            ocnt_q   <= '0;
`endif
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            bidx_q   <= bidx_d;
            bcnt_q   <= bcnt_d;
            mode_q   <= mode_d;
            fg_q     <= fg_d;
            bg_q     <= bg_d;
            rgb_q    <= rgb_d;
            valid_q  <= valid_d;
            fstart_q <= fstart_d;
            fcnt_q   <= fcnt_d;
`ifdef LCD_PATTERN_SCROLL_EN
            off_q    <= off_d;
            xs_q     <= xs_d;
            oidx_q   <= oidx_d;
            ocnt_q   <= ocnt_d;
`endif
        end
    end

    assign rgb         = rgb_q;
    assign data_valid  = valid_q;
    assign frame_start = fstart_q;
    assign frame_cnt   = fcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_lcd_pattern_gen.sv
// tb_lcd_pattern_gen: randomized scoreboard bench for lcd_pattern_gen against a raster-level reference model.
`default_nettype none

module tb_lcd_pattern_gen;

    localparam int H  = 300;
    localparam int V  = 3;
    localparam int CL = 2;
    localparam int GS = 0;
    localparam int FW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    mode;
    logic [23:0]   color_fg, color_bg;
    logic          enable, frame_sync, data_req;
    logic [23:0]   rgb;
    logic          data_valid, frame_start;
    logic [FW-1:0] frame_cnt;

    lcd_pattern_gen #(
        .H_ACTIVE(H), .V_ACTIVE(V), .CHECK_LOG2(CL), .GRAD_SHIFT(GS), .FRAME_CNT_W(FW)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .color_fg(color_fg), .color_bg(color_bg),
        .enable(enable), .frame_sync(frame_sync), .data_req(data_req),
        .rgb(rgb), .data_valid(data_valid), .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0]   rgb;
        logic          fs;
        logic [FW-1:0] fc;
    } exp_t;

    exp_t q[$];
    int errors = 0;
    int checks = 0;

    int mx, my, mfc, moff;
    logic [1:0]  smode;
    logic [23:0] sfg, sbg;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] bar_col(input int i);
        case (i)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    task automatic model_reset();
        mx = 0; my = 0; mfc = 0; moff = 0;
        smode = 2'd0; sfg = 24'd0; sbg = 24'd0;
    endtask

    // Drive one cycle's request/sync at the negedge and record what the DUT must answer
    task automatic issue(input bit req, input bit sync);
        exp_t e;
        int xs, g, bi;
        logic [23:0] p;
        bit origin;
        data_req   = req;
        frame_sync = sync;
        if (sync) begin mx = 0; my = 0; end
        if (req) begin
            origin = (mx == 0) && (my == 0);
            if (origin) begin smode = mode; sfg = color_fg; sbg = color_bg; end
`ifdef LCD_PATTERN_SCROLL_EN
            xs = (mx + moff) % H;
`else
            xs = mx;
`endif
            if (!enable) p = sbg;
            else begin
                case (smode)
                    2'd0: p = sfg;
                    2'd1: begin bi = xs / (H / 8); if (bi > 7) bi = 7; p = bar_col(bi); end
                    2'd2: p = ((((xs >> CL) ^ (my >> CL)) & 1) == 0) ? sfg : sbg;
                    default: begin g = xs >> GS; if (g > 255) g = 255; p = {3{8'(g)}}; end
                endcase
            end
            if (mx == H - 1) begin
                mx = 0;
                if (my == V - 1) begin
                    my = 0;
                    mfc = (mfc + 1) % (1 << FW);
                    moff = (moff + 1) % H;
                end else my++;
            end else mx++;
            e.rgb = p; e.fs = origin; e.fc = FW'(mfc);
            q.push_back(e);
        end
    endtask

    task automatic cycle(input bit req, input bit sync);
        @(negedge clk);
        issue(req, sync);
    endtask

    // Monitor: pops expectations whenever the DUT presents a pixel
    logic [23:0] last_rgb = 24'd0;
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (!rst) last_rgb = 24'd0;
            else if (data_valid) begin
                if (q.size() == 0) chk("spurious_valid", 32'(data_valid), 32'd0);
                else begin
                    e = q.pop_front();
                    chk("rgb", 32'(rgb), 32'(e.rgb));
                    chk("frame_start", 32'(frame_start), 32'(e.fs));
                    chk("frame_cnt", 32'(frame_cnt), 32'(e.fc));
                    last_rgb = e.rgb;
                end
            end else begin
                chk("rgb_hold", 32'(rgb), 32'(last_rgb));
                chk("idle_frame_start", 32'(frame_start), 32'd0);
            end
        end
    end

    initial begin
        int rate;
        rst = 1'b0; mode = 2'd0; color_fg = 24'd0; color_bg = 24'd0;
        enable = 1'b1; frame_sync = 1'b0; data_req = 1'b0;
        model_reset();
        #12;
        chk("reset_rgb", 32'(rgb), 32'd0);
        chk("reset_valid", 32'(data_valid), 32'd0);
        chk("reset_fstart", 32'(frame_start), 32'd0);
        chk("reset_fcnt", 32'(frame_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Solid blue, continuous requests across two full frames
        mode = 2'd0; color_fg = 24'h0000FF; color_bg = 24'h123456;
        repeat (2 * H * V + 5) cycle(1'b1, 1'b0);

        // Randomized traffic: live inputs change mid-frame, gaps, rare syncs, blanking
        for (int seg = 0; seg < 8; seg++) begin
            rate = (seg % 2 == 0) ? 4 : 1;
            for (int c = 0; c < 1800; c++) begin
                @(negedge clk);
                if ($urandom_range(0, 49) == 0) begin
                    mode     = 2'($urandom_range(0, 3));
                    color_fg = 24'($urandom);
                    color_bg = 24'($urandom);
                end
                enable = ($urandom_range(0, 15) != 0);
                issue(($urandom_range(0, 4) < rate), ($urandom_range(0, 399) == 0));
            end
        end

        // Async reset while a pixel is being presented
        enable = 1'b1; mode = 2'd2; color_fg = 24'hFFFFFF; color_bg = 24'h000000;
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("async_rgb", 32'(rgb), 32'd0);
        chk("async_valid", 32'(data_valid), 32'd0);
        chk("async_fcnt", 32'(frame_cnt), 32'd0);
        model_reset();
        data_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Gapped requests up to (5,1), then frame_sync with a request
        mode = 2'd1;
        for (int i = 0; i < H + 5; i++) begin
            cycle(1'b1, 1'b0);
            cycle(1'b0, 1'b0);
            cycle(1'b0, 1'b0);
        end
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b0);
        repeat (20) cycle(1'b1, 1'b0);

        cycle(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("drain", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
